inta_sequencer: RTL and testbench

CPU-side interrupt-acknowledge master that sits directly downstream of the interrupt controller. It consumes the controller's `INT` output, runs the two-pulse 8086-style `INTA` sequence back into the controller, and captures the 8-bit vector the controller drives on `DATABUS` during the second pulse. The captured vector is handed to the core over a valid/ready handshake. It is the only driver of the controller's `INTA` pin.

---
 rtl/inta_sequencer.sv | 118 +++++++++++
 tb/tb_inta_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge master: runs the two-pulse INTA sequence against the
// interrupt controller and hands the captured vector to the core (valid/ready).
module inta_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  input  logic       ien,
  input  logic [7:0] DATABUS,
  output logic       INTA,
  output logic [7:0] vector,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Handshake: vector is offered while vec_valid=1 and is consumed at the
  // rising clk edge where vec_valid=1 and vec_ready=1; vector and vec_valid
  // hold steady until that edge, and vec_ready is ignored at all other times.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK1    = 3'd1,
    GAP     = 3'd2,
    ACK2    = 3'd3,
    HOLD    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   int_s;
  logic                   expired;
  logic                   capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], INT};
  end

  assign int_s     = sync_q[SYNC_STAGES-1];
  assign expired   = (cnt == 4'd0);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = expired ? cnt : cnt - 4'd1;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (int_s && ien) begin
          state_nxt = ACK1;
          cnt_nxt   = PULSE_LOAD;
        end
      end
      ACK1: begin
        if (expired) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end
      end
      GAP: begin
        if (expired) begin
          state_nxt = ACK2;
          cnt_nxt   = PULSE_LOAD;
        end
      end
      ACK2: begin
        if (expired) begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end
      end
      HOLD: begin
        if (vec_ready) begin
          state_nxt = RECOVER;
          cnt_nxt   = GAP_LOAD;
        end
      end
      RECOVER: begin
        // int_s is deliberately not looked at here so a stale request cannot retrigger.
        if (expired) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs are registered decodes of the next state, so they move only on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      INTA      <= 1'b1;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      vector    <= 8'h00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      INTA      <= !((state_nxt == ACK1) || (state_nxt == ACK2));
      vec_valid <= (state_nxt == HOLD);
      busy      <= (state_nxt != IDLE);
      if (capture) vector <= DATABUS;
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: randomized directed sequences checked against a
// timeline model derived from the pulse/gap/sync cycle counts.
module tb_inta_sequencer;
  localparam int S = 2;
  localparam int P = 2;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       int_r = 1'b0;
  logic       ien = 1'b0;
  logic [7:0] databus = 8'h00;
  logic       vec_ready = 1'b0;
  logic       inta;
  logic [7:0] vector;
  logic       vec_valid;
  logic       busy;
  logic [2:0] dbg_state;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  logic [7:0] prev_vec = 8'h00;
  int         idle_at;

  inta_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .INT(int_r), .ien(ien), .DATABUS(databus),
    .INTA(inta), .vector(vector), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_inta", 8'(inta), 8'h01);
      chk("idle_valid", 8'(vec_valid), 8'h00);
      chk("idle_busy", 8'(busy), 8'h00);
      chk("idle_vector", vector, prev_vec);
    end
  endtask

  // f: edge index entering the first pulse. mode 1 drops INT and ien on GAP
  // entry, mode 2 drops INT when the second pulse begins, mode 0 keeps INT.
  task automatic run_seq(input int f, input logic [7:0] vec, input int stall,
                         input int mode, output int idle_o);
    int   g, a2, v, acc, idle, c;
    logic e_inta, e_valid, e_busy;
    g    = f + P;
    a2   = g + G;
    v    = a2 + P;
    acc  = v + stall + 1;
    idle = acc + G;
    while (cyc <= idle) begin
      c       = cyc;
      e_inta  = !((c >= f && c < g) || (c >= a2 && c < v));
      e_valid = (c >= v) && (c < acc);
      e_busy  = (c >= f) && (c < idle);
      chk("inta", 8'(inta), 8'(e_inta));
      chk("vec_valid", 8'(vec_valid), 8'(e_valid));
      chk("busy", 8'(busy), 8'(e_busy));
      chk("vector", vector, (c >= v) ? vec : prev_vec);
      if (c == idle) break;
      vec_ready = (c < v) ? 1'($urandom_range(0, 1)) : ((c - v) >= stall);
      databus   = (c >= a2 && c < v) ? vec : 8'($urandom);
      if (mode == 1 && c == g) begin
        int_r = 1'b0;
        ien   = 1'b0;
      end
      if (mode == 2 && c == a2) int_r = 1'b0;
      step();
    end
    prev_vec = vec;
    idle_o   = idle;
  endtask

  initial begin
    int a2;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_inta", 8'(inta), 8'h01);
    chk("rst_valid", 8'(vec_valid), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_vector", vector, 8'h00);
    step();
    step();
    rst_n = 1'b1;
    chk_idle(3);

    // Basic sequence with the core always ready.
    ien = 1'b1;
    vec_ready = 1'b1;
    int_r = 1'b1;
    run_seq(cyc + 1 + S, 8'h4B, 0, 2, idle_at);
    chk_idle(3);

    // Core stalls five cycles in HOLD.
    int_r = 1'b1;
    run_seq(cyc + 1 + S, 8'($urandom), 5, 2, idle_at);
    chk_idle(2);

    for (int i = 0; i < 3; i++) begin
      int_r = 1'b1;
      run_seq(cyc + 1 + S, 8'($urandom), int'($urandom_range(0, 6)), 2, idle_at);
      chk_idle(int'($urandom_range(1, 4)));
    end

    // ien low holds the FSM in IDLE; raising it starts on the next edge.
    ien = 1'b0;
    int_r = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ien_hold_inta", 8'(inta), 8'h01);
      chk("ien_hold_busy", 8'(busy), 8'h00);
    end
    ien = 1'b1;
    run_seq(cyc + 1, 8'($urandom), int'($urandom_range(0, 3)), 2, idle_at);
    chk_idle(2);

    // INT and ien dropped in GAP: the sequence still completes.
    int_r = 1'b1;
    run_seq(cyc + 1 + S, 8'($urandom), int'($urandom_range(0, 3)), 1, idle_at);
    chk_idle(4);
    ien = 1'b1;
    chk_idle(2);

    // INT held across two back-to-back vectors.
    int_r = 1'b1;
    run_seq(cyc + 1 + S, 8'h20, int'($urandom_range(0, 3)), 0, idle_at);
    run_seq(idle_at + 1, 8'h27, int'($urandom_range(0, 3)), 2, idle_at);
    chk_idle(3);

    // Reset asserted mid-ACK2.
    int_r = 1'b1;
    a2 = cyc + 1 + S + P + G;
    databus = 8'h99;
    while (cyc < a2) step();
    chk("pre_rst_inta", 8'(inta), 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_inta", 8'(inta), 8'h01);
    chk("async_rst_valid", 8'(vec_valid), 8'h00);
    chk("async_rst_vector", vector, 8'h00);
    chk("async_rst_busy", 8'(busy), 8'h00);
    int_r = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    prev_vec = 8'h00;
    chk_idle(4);

    int_r = 1'b1;
    run_seq(cyc + 1 + S, 8'($urandom), int'($urandom_range(0, 4)), 2, idle_at);
    chk_idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
